// File: rtl/mobilenet_mem_pkg.sv
// Constants and state encoding shared by the IFM unpacker and the OFM packer.
// Both sides agree on slot order: slot 0 occupies the low bits of a beat.
package mobilenet_mem_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int AXI_DATA_W_DEF = 128;
    localparam int PACK_FACTOR    = AXI_DATA_W_DEF / DATA_W_DEF;
    localparam int PF_BITS        = $clog2(PACK_FACTOR);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } unpack_state_e;

endpackage

// File: rtl/ifm_unpacker_if.sv
// Stream bundle for the unpacker: AXI-Stream beats in, scalar elements out.
// The slave modport is the unpacker's view; master is the surrounding fabric.
interface ifm_unpacker_if #(
    parameter int DATA_W     = 16,
    parameter int AXI_DATA_W = 128
);
    logic [AXI_DATA_W-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tlast;
    logic                  s_axis_tready;
    logic [DATA_W-1:0]     m_elem_data;
    logic                  m_elem_valid;
    logic                  m_elem_last;
    logic                  m_elem_ready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_elem_ready,
        output s_axis_tready, m_elem_data, m_elem_valid, m_elem_last
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_elem_ready,
        input  s_axis_tready, m_elem_data, m_elem_valid, m_elem_last
    );
endinterface

// File: rtl/elem_slot_mux.sv
// Selects one DATA_W element out of a held AXI beat; slot 0 is the low bits.
module elem_slot_mux #(
    parameter int DATA_W     = 16,
    parameter int AXI_DATA_W = 128,
    parameter int SLOT_W     = 3
) (
    input  logic [AXI_DATA_W-1:0] hold_reg,
    input  logic [SLOT_W-1:0]     slot,
    output logic [DATA_W-1:0]     elem
);
    localparam int PACK = AXI_DATA_W / DATA_W;

    always_comb begin
        elem = '0;
        for (int i = 0; i < PACK; i++) begin
            if (slot == i[SLOT_W-1:0]) begin
                elem = hold_reg[i*DATA_W +: DATA_W];
            end
        end
    end
endmodule

// File: rtl/ifm_unpacker.sv
// Unpacks 128-bit DDR beats into a scalar element stream for the compute engine,
// trimming a partial final beat and flagging bursts that end early via tlast.
//
// state | meaning
// IDLE  | waiting for start
// FILL  | requesting the next beat (tready=1)
// EMIT  | presenting held elements one per handshake
// DONE  | one-cycle done pulse, then back to IDLE
module ifm_unpacker
    import mobilenet_mem_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int AXI_DATA_W = AXI_DATA_W_DEF,
    parameter int CNT_W      = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] total_elems,
    output logic             busy,
    output logic             done,
    output logic             err_early_last,
    ifm_unpacker_if.slave    axis
);
    localparam int PACK = AXI_DATA_W / DATA_W;
    localparam int PFB  = $clog2(PACK);
    localparam logic [CNT_W-1:0] PACK_CNT = CNT_W'(PACK);
    localparam logic [PFB:0]     PACK_BE  = (PFB+1)'(PACK);

    unpack_state_e         state;
    logic [AXI_DATA_W-1:0] hold_reg;
    logic [PFB-1:0]        slot;
    logic [PFB:0]          beat_elems;
    logic                  beat_final;
    logic [CNT_W-1:0]      remaining;
    logic                  elem_valid;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [DATA_W-1:0]     elem_data;

    logic             elem_hs;
    logic             slot_last;
    logic             tready;
    logic             beat_hs;
    logic [CNT_W-1:0] rem_next;
    logic [PFB:0]     beat_elems_next;
    logic             beat_final_next;
    logic             early_last;

    assign elem_hs   = elem_valid & axis.m_elem_ready;
    assign slot_last = ({1'b0, slot} == (beat_elems - 1'b1));

    // A beat may also be taken while the last slot of a non-final beat leaves,
    // which keeps the element stream free of bubbles between beats.
    assign tready  = (state == ST_FILL) |
                     ((state == ST_EMIT) & elem_hs & slot_last & ~beat_final);
    assign beat_hs = tready & axis.s_axis_tvalid;

    assign rem_next        = remaining - CNT_W'(elem_hs);
    assign beat_elems_next = (rem_next >= PACK_CNT) ? PACK_BE : rem_next[PFB:0];
    assign beat_final_next = axis.s_axis_tlast | (rem_next <= PACK_CNT);
    assign early_last      = axis.s_axis_tlast & (rem_next > PACK_CNT);

    elem_slot_mux #(
        .DATA_W     (DATA_W),
        .AXI_DATA_W (AXI_DATA_W),
        .SLOT_W     (PFB)
    ) u_slot_mux (
        .hold_reg (hold_reg),
        .slot     (slot),
        .elem     (elem_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            hold_reg   <= '0;
            slot       <= '0;
            beat_elems <= '0;
            beat_final <= 1'b0;
            remaining  <= '0;
            elem_valid <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err_q <= 1'b0;
                        if (total_elems != '0) begin
                            remaining <= total_elems;
                            busy_q    <= 1'b1;
                            state     <= ST_FILL;
                        end else begin
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_FILL: begin
                    if (beat_hs) begin
                        elem_valid <= 1'b1;
                        state      <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (elem_hs) begin
                        remaining <= rem_next;
                        slot      <= slot + 1'b1;
                        if (slot_last) begin
                            // beat_final covers both count exhaustion and early tlast
                            if (beat_final) begin
                                elem_valid <= 1'b0;
                                busy_q     <= 1'b0;
                                done_q     <= 1'b1;
                                state      <= ST_DONE;
                            end else if (!beat_hs) begin
                                elem_valid <= 1'b0;
                                state      <= ST_FILL;
                            end
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            if (beat_hs) begin
                hold_reg   <= axis.s_axis_tdata;
                slot       <= '0;
                beat_elems <= beat_elems_next;
                beat_final <= beat_final_next;
                if (early_last) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign axis.s_axis_tready = tready;
    assign axis.m_elem_valid  = elem_valid;
    assign axis.m_elem_data   = elem_data;
    assign axis.m_elem_last   = elem_valid & beat_final & slot_last;
    assign busy               = busy_q;
    assign done               = done_q;
    assign err_early_last     = err_q;
endmodule

// File: tb/tb_ifm_unpacker.sv
// Bench for ifm_unpacker: table of transfers checked against a queue of expected
// elements, plus hand sequences for zero-length and mid-transfer reset.
module tb_ifm_unpacker;
    import mobilenet_mem_pkg::*;

    localparam int DW = DATA_W_DEF;
    localparam int AW = AXI_DATA_W_DEF;
    localparam int CW = 20;
    localparam int PK = PACK_FACTOR;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] total_elems = '0;
    logic          busy;
    logic          done;
    logic          err_early_last;

    ifm_unpacker_if #(.DATA_W(DW), .AXI_DATA_W(AW)) bus ();

    ifm_unpacker #(.DATA_W(DW), .AXI_DATA_W(AW), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .total_elems    (total_elems),
        .busy           (busy),
        .done           (done),
        .err_early_last (err_early_last),
        .axis           (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } elem_t;

    typedef struct {
        int total;
        int tlast_beat;   // 1-based beat carrying tlast, 0 = none
        int mode;         // 0 ready=1, 1 toggling, 2 random
        int load;         // beats offered
        int exp_elems;
        int exp_beats;
        bit exp_err;
    } vec_t;

    elem_t         exp_q[$];
    logic [AW-1:0] beat_q[$];
    logic          tlast_q[$];

    int checks = 0;
    int errors = 0;

    int cyc = 0, beats_taken = 0, elem_cnt = 0, elems_in_beat = 0;
    int stab_viol = 0, tready_viol = 0, tready_cycles = 0, valid_cycles = 0;
    int done_count = 0, done_cyc = 0, first_cyc = 0, last_cyc = 0;
    int ready_mode = 0;
    bit first_pending = 0;
    logic stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;
    logic stall_last = 1'b0;
    logic b_hs, e_hs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Source, sink and monitor: samples at negedge, drives just after posedge.
    initial begin : bg
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = 1'b0;
        bus.m_elem_ready  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            b_hs = bus.s_axis_tvalid & bus.s_axis_tready & ~rst;
            e_hs = bus.m_elem_valid & bus.m_elem_ready & ~rst;
            if (!rst && bus.s_axis_tready) tready_cycles++;
            if (!rst && bus.m_elem_valid) valid_cycles++;
            if (!rst && done) begin
                done_count++;
                done_cyc = cyc;
            end
            if (!rst && start) first_pending = 1;
            if (stall_prev && !rst &&
                (!bus.m_elem_valid || bus.m_elem_data !== stall_data || bus.m_elem_last !== stall_last))
                stab_viol++;
            stall_prev = ~rst & bus.m_elem_valid & ~bus.m_elem_ready;
            stall_data = bus.m_elem_data;
            stall_last = bus.m_elem_last;
            if (!rst && bus.s_axis_tready && bus.m_elem_valid &&
                !(bus.m_elem_ready && elems_in_beat == PK - 1))
                tready_viol++;
            if (e_hs) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_elem actual=%0h required=none", bus.m_elem_data);
                end else begin
                    elem_t e;
                    e = exp_q.pop_front();
                    chk("elem_data", 64'(bus.m_elem_data), 64'(e.data));
                    chk("elem_last", 64'(bus.m_elem_last), 64'(e.last));
                end
                if (first_pending) begin
                    first_cyc = cyc;
                    first_pending = 0;
                end
                last_cyc = cyc;
                elem_cnt++;
                elems_in_beat++;
            end
            if (b_hs) begin
                beats_taken++;
                elems_in_beat = 0;
                if (beat_q.size() > 0) begin
                    void'(beat_q.pop_front());
                    void'(tlast_q.pop_front());
                end
            end
            if (rst) elems_in_beat = 0;
            @(posedge clk);
            #1;
            if (beat_q.size() > 0) begin
                bus.s_axis_tvalid = 1'b1;
                bus.s_axis_tdata  = beat_q[0];
                bus.s_axis_tlast  = tlast_q[0];
            end else begin
                bus.s_axis_tvalid = 1'b0;
                bus.s_axis_tdata  = '0;
                bus.s_axis_tlast  = 1'b0;
            end
            case (ready_mode)
                1:       bus.m_elem_ready = (cyc % 2 == 0);
                2:       bus.m_elem_ready = 1'($urandom_range(0, 1));
                default: bus.m_elem_ready = 1'b1;
            endcase
        end
    end

    task automatic load_beats(input int t, input vec_t v);
        logic [DW-1:0] base;
        base = DW'(t * 256);
        beat_q.delete();
        tlast_q.delete();
        for (int b = 0; b < v.load; b++) begin
            logic [AW-1:0] beat;
            for (int i = 0; i < PK; i++) beat[i*DW +: DW] = base + DW'(b * PK + i);
            beat_q.push_back(beat);
            tlast_q.push_back(b + 1 == v.tlast_beat);
        end
        for (int k = 0; k < v.exp_elems; k++) begin
            elem_t e;
            e.data = base + DW'(k);
            e.last = (k == v.exp_elems - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_vec(input int t, input vec_t v);
        int b0, dc0, sv0, tv0;
        load_beats(t, v);
        ready_mode = v.mode;
        b0  = beats_taken;
        dc0 = done_count;
        sv0 = stab_viol;
        tv0 = tready_viol;
        start = 1'b1;
        total_elems = CW'(v.total);
        tick();
        start = 1'b0;
        chk($sformatf("v%0d_busy_after_start", t), 64'(busy), 64'(1));
        chk($sformatf("v%0d_err_cleared", t), 64'(err_early_last), 64'(0));
        for (int i = 0; i < 2000 && done_count == dc0; i++) tick();
        tick();
        tick();
        chk($sformatf("v%0d_done_pulses", t), 64'(done_count - dc0), 64'(1));
        chk($sformatf("v%0d_leftover_expected", t), 64'(exp_q.size()), 64'(0));
        chk($sformatf("v%0d_beats_taken", t), 64'(beats_taken - b0), 64'(v.exp_beats));
        chk($sformatf("v%0d_err_early_last", t), 64'(err_early_last), 64'(v.exp_err));
        chk($sformatf("v%0d_done_after_last", t), 64'(done_cyc - last_cyc), 64'(1));
        chk($sformatf("v%0d_busy_idle", t), 64'(busy), 64'(0));
        chk($sformatf("v%0d_stall_stability", t), 64'(stab_viol - sv0), 64'(0));
        chk($sformatf("v%0d_tready_early", t), 64'(tready_viol - tv0), 64'(0));
        if (v.mode == 0)
            chk($sformatf("v%0d_elem_span", t), 64'(last_cyc - first_cyc), 64'(v.exp_elems - 1));
        exp_q.delete();
        beat_q.delete();
        tlast_q.delete();
    endtask

    vec_t vecs[8];

    initial begin : main
        int tc0, vc0, e0;
        vec_t v;
        vecs[0] = '{16, 2, 0, 3, 16, 2, 1'b0};
        vecs[1] = '{13, 2, 0, 3, 13, 2, 1'b0};
        vecs[2] = '{16, 2, 1, 2, 16, 2, 1'b0};
        vecs[3] = '{24, 2, 0, 3, 16, 2, 1'b1};
        vecs[4] = '{ 8, 0, 0, 2,  8, 1, 1'b0};
        vecs[5] = '{ 5, 1, 2, 1,  5, 1, 1'b0};
        vecs[6] = '{37, 5, 2, 6, 37, 5, 1'b0};
        vecs[7] = '{20, 1, 1, 3,  8, 1, 1'b1};

        tick();
        tick();
        chk("reset_valid", 64'(bus.m_elem_valid), 64'(0));
        chk("reset_tready", 64'(bus.s_axis_tready), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_err", 64'(err_early_last), 64'(0));
        chk("reset_data", 64'(bus.m_elem_data), 64'(0));
        rst = 1'b0;
        tick();

        for (int t = 0; t < 8; t++) run_vec(t, vecs[t]);

        // Zero-length transfer: done on the cycle after start, nothing moves.
        tc0 = tready_cycles;
        vc0 = valid_cycles;
        ready_mode = 0;
        start = 1'b1;
        total_elems = '0;
        chk("zero_done_not_yet", 64'(done), 64'(0));
        tick();
        start = 1'b0;
        chk("zero_done_pulse", 64'(done), 64'(1));
        chk("zero_busy", 64'(busy), 64'(0));
        tick();
        chk("zero_done_drop", 64'(done), 64'(0));
        tick();
        chk("zero_no_tready", 64'(tready_cycles - tc0), 64'(0));
        chk("zero_no_valid", 64'(valid_cycles - vc0), 64'(0));

        // Reset after a few elements of a 16-element transfer.
        v = '{16, 2, 0, 2, 16, 2, 1'b0};
        load_beats(8, v);
        ready_mode = 0;
        e0 = elem_cnt;
        start = 1'b1;
        total_elems = CW'(16);
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && elem_cnt - e0 < 3; i++) tick();
        chk("rst_reached_3_elems", 64'(elem_cnt - e0 >= 3), 64'(1));
        rst = 1'b1;
        tick();
        chk("rst_valid", 64'(bus.m_elem_valid), 64'(0));
        chk("rst_tready", 64'(bus.s_axis_tready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_last", 64'(bus.m_elem_last), 64'(0));
        chk("rst_data", 64'(bus.m_elem_data), 64'(0));
        rst = 1'b0;
        exp_q.delete();
        beat_q.delete();
        tlast_q.delete();
        tick();
        run_vec(9, '{8, 1, 0, 2, 8, 1, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end
endmodule
